floor_request_scheduler: RTL and testbench
==========================================

// Module: floor_request_scheduler
// PURPOSE
//  Collects car-panel and hall call buttons into a pending-request register.
//  Sequences the single elevator car, issuing one target floor at a time.
//  Target choice is directional (collective/SCAN): serve nearest pending floor
//  in the current direction, reverse only when none remain ahead.
//  Sits between button debouncers and the elevator FSM's in/open_door inputs;
//  monitors the FSM's state/floor/status_door/sos_en outputs.
// PARAMETERS
//  NFLOORS   4   number of floors; floors numbered 1..NFLOORS, bit i = floor i+1
//  FLOOR_W   4   width of binary floor / target buses
//  ST_W      4   width of elevator state code
//  IDLE_CODE 0   elevator FSM state code meaning idle
// PORTS
//  clk        in   1         single clock; all logic on posedge
//  rst        in   1         synchronous, active-high reset
//  car_btn    in   NFLOORS   car-panel buttons, level, bit i = floor i+1
//  hall_btn   in   NFLOORS   hall call buttons (up/down merged), level
//  floor      in   FLOOR_W   current car floor from elevator FSM (binary)
//  el_state   in   ST_W      elevator FSM state code
//  door_open  in   1         elevator status_door
//  sos_en     in   1         elevator sos_en
//  req_floor  out  FLOOR_W   target to elevator 'in' port; 0 = no request
//  open_req   out  1         to elevator open_door; re-open at current floor
//  pending    out  NFLOORS   latched requests (button lamps)
//  dir        out  1         travel preference: 0 = up, 1 = down
//  busy       out  1         high in S_ISSUE/S_BUSY
// BEHAVIOUR
//  Reset (sync, priority over everything): state=S_SELECT, req_floor=0,
//   open_req=0, pending=0, dir=0 (up), busy=0. Applies mid-operation too.
//  Pending: each cycle pending <= (pending | car_btn | hall_btn) & ~clr;
//   clr = onehot(floor) when door_open && floor valid, else 0. Clear wins over
//   simultaneous press of same floor. Lamp visible 1 cycle after press.
//  Floor valid iff 1 <= floor <= NFLOORS; invalid floor: no clear, no issue.
//  Target pick (combinational, from pending & floor & dir):
//   above = lowest pending floor > floor; below = highest pending floor < floor.
//   dir=up:   above exists -> above; else below exists -> below, dir<=1.
//   dir=down: below exists -> below; else above exists -> above, dir<=0.
//   neither, but pending[floor] set -> "reopen" (open_req path).
//  FSM, all outputs registered:
//   S_SELECT: if sos_en -> S_HALT. Else if el_state==IDLE_CODE, floor valid,
//     pending!=0: load req_floor=target (or open_req=1 for reopen), update
//     dir, -> S_ISSUE. Otherwise stay; req_floor=0, open_req=0.
//   S_ISSUE: hold req_floor/open_req until el_state!=IDLE_CODE (ack); on ack
//     clear req_floor and open_req, -> S_BUSY. Issue-to-ack latency = 1 cycle
//     nominal (elevator leaves idle the cycle after sampling).
//   S_BUSY: wait until el_state==IDLE_CODE && !door_open -> S_SELECT.
//     Presses during S_BUSY latch into pending only; no preemption.
//   S_HALT: req_floor=0, open_req=0, pending frozen (buttons ignored),
//     busy=0; exit only via rst.
//   sos_en in any state -> S_HALT next cycle, outputs zeroed in that cycle.
//  Intermediate floors are never skipped: target is always nearest in dir.
//  Widths: floor compared unsigned at FLOOR_W; target encoded as index+1.
// STRUCTURE
//  Package elevator_pkg: FSM state codes, IDLE_CODE, UP=0/DOWN=1, NFLOORS.
//  Sub-module target_picker (combinational): pending, floor, dir ->
//   target, new_dir, reopen, found. Top holds pending reg and scheduler FSM.
// TESTING
//  1. Car at 1, idle; press car_btn=4'b1100 -> req_floor=3 first; after
//     door_open at 3, pending=4'b1000, next issue req_floor=4.
//  2. Car at 3, dir=up, pending floors 1,2 only -> req_floor=2, dir=1.
//  3. Car at 2 idle, press hall_btn floor 2 (door closed) -> open_req=1
//     held until el_state!=0, req_floor stays 0.
//  4. door_open at floor 3 while car_btn[2]=1 -> pending[2] stays 0.
//  5. sos_en=1 during S_BUSY -> next cycle req_floor=0, S_HALT; presses
//     ignored; only rst returns to S_SELECT with pending=0.
//  6. rst during S_ISSUE (req_floor=4) -> next cycle req_floor=0, dir=0,
//     pending=0, busy=0.

Source files
------------

// File: rtl/floor_request_scheduler_pkg.sv
// Shared constants, FSM state codes and floor helpers for the elevator request scheduler.
package elevator_pkg;

  localparam int NFLOORS = 4;
  localparam int FLOOR_W = 4;
  localparam int ST_W    = 4;

  localparam logic [ST_W-1:0] IDLE_CODE = 4'd0;
  localparam logic            UP        = 1'b0;
  localparam logic            DOWN      = 1'b1;

  typedef enum logic [1:0] {
    S_SELECT = 2'd0,
    S_ISSUE  = 2'd1,
    S_BUSY   = 2'd2,
    S_HALT   = 2'd3
  } sched_state_t;

  function automatic logic floor_valid(input logic [FLOOR_W-1:0] f);
    return (f >= FLOOR_W'(1)) && (f <= FLOOR_W'(NFLOORS));
  endfunction

  // Out-of-range floors map to all-zeros so they never clear or match a request.
  function automatic logic [NFLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] f);
    logic [NFLOORS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NFLOORS; i++) begin
      oh[i] = (f == FLOOR_W'(i + 1));
    end
    return oh;
  endfunction

endpackage

// File: rtl/floor_request_scheduler_if.sv
// Command/status link between the request scheduler and the elevator car FSM.
interface floor_request_scheduler_if;

  logic [elevator_pkg::FLOOR_W-1:0] req_floor;
  logic                             open_req;
  logic [elevator_pkg::FLOOR_W-1:0] floor;
  logic [elevator_pkg::ST_W-1:0]    el_state;
  logic                             door_open;
  logic                             sos_en;

  modport master (output req_floor, open_req, input floor, el_state, door_open, sos_en);
  modport slave  (input req_floor, open_req, output floor, el_state, door_open, sos_en);

endinterface

// File: rtl/floor_request_scheduler_target_picker.sv
// Collective (SCAN) target choice: nearest pending floor in the travel direction.
module target_picker
  import elevator_pkg::*;
(
  input  logic [NFLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0] floor,
  input  logic               dir,
  output logic [FLOOR_W-1:0] target,
  output logic               new_dir,
  output logic               reopen,
  output logic               found
);

  logic [FLOOR_W-1:0] above_s;
  logic [FLOOR_W-1:0] below_s;
  logic               above_found_s;
  logic               below_found_s;

  // Scan downward for the lowest floor above, upward for the highest floor below.
  always_comb begin
    above_s       = '0;
    below_s       = '0;
    above_found_s = 1'b0;
    below_found_s = 1'b0;
    for (int i = NFLOORS - 1; i >= 0; i--) begin
      above_s       = (pending[i] && (FLOOR_W'(i + 1) > floor)) ? FLOOR_W'(i + 1) : above_s;
      above_found_s = above_found_s | (pending[i] && (FLOOR_W'(i + 1) > floor));
    end
    for (int i = 0; i < NFLOORS; i++) begin
      below_s       = (pending[i] && (FLOOR_W'(i + 1) < floor)) ? FLOOR_W'(i + 1) : below_s;
      below_found_s = below_found_s | (pending[i] && (FLOOR_W'(i + 1) < floor));
    end
  end

  // Prefer the current direction; reverse only when nothing remains ahead.
  always_comb begin
    target  = '0;
    new_dir = dir;
    if (dir == UP) begin
      if (above_found_s) begin
        target  = above_s;
        new_dir = UP;
      end else if (below_found_s) begin
        target  = below_s;
        new_dir = DOWN;
      end else begin
        target  = '0;
        new_dir = dir;
      end
    end else begin
      if (below_found_s) begin
        target  = below_s;
        new_dir = DOWN;
      end else if (above_found_s) begin
        target  = above_s;
        new_dir = UP;
      end else begin
        target  = '0;
        new_dir = dir;
      end
    end
    found  = above_found_s | below_found_s;
    reopen = !(above_found_s | below_found_s) && (|(pending & floor_onehot(floor)));
  end

endmodule

// File: rtl/floor_request_scheduler.sv
// Latches call buttons and issues one target floor (or a door re-open) at a time to the car FSM.
module floor_request_scheduler
  import elevator_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NFLOORS-1:0]         car_btn,
  input  logic [NFLOORS-1:0]         hall_btn,
  floor_request_scheduler_if.master  el,
  output logic [NFLOORS-1:0]         pending,
  output logic                       dir,
  output logic                       busy
);

  sched_state_t       state_r;
  logic [NFLOORS-1:0] clr_s;
  logic [NFLOORS-1:0] next_pending_s;
  logic [FLOOR_W-1:0] target_s;
  logic               new_dir_s;
  logic               reopen_s;
  logic               found_s;

  target_picker u_picker (
    .pending (pending),
    .floor   (el.floor),
    .dir     (dir),
    .target  (target_s),
    .new_dir (new_dir_s),
    .reopen  (reopen_s),
    .found   (found_s)
  );

  // An open door at a valid floor cancels that floor's lamp, even against a fresh press.
  always_comb begin
    if (el.door_open) begin
      clr_s = floor_onehot(el.floor);
    end else begin
      clr_s = '0;
    end
    next_pending_s = (pending | car_btn | hall_btn) & ~clr_s;
  end

  // Scheduler FSM; sos_en overrides every state and only rst leaves S_HALT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_SELECT;
      el.req_floor <= '0;
      el.open_req  <= 1'b0;
      pending      <= '0;
      dir          <= UP;
      busy         <= 1'b0;
    end else if (el.sos_en || (state_r == S_HALT)) begin
      state_r      <= S_HALT;
      el.req_floor <= '0;
      el.open_req  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      pending <= next_pending_s;
      case (state_r)
        S_SELECT: begin
          if ((el.el_state == IDLE_CODE) && floor_valid(el.floor) && (pending != '0)
              && (found_s || reopen_s)) begin
            el.req_floor <= found_s ? target_s : '0;
            el.open_req  <= !found_s;
            dir          <= found_s ? new_dir_s : dir;
            busy         <= 1'b1;
            state_r      <= S_ISSUE;
          end else begin
            el.req_floor <= '0;
            el.open_req  <= 1'b0;
            busy         <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (el.el_state != IDLE_CODE) begin
            el.req_floor <= '0;
            el.open_req  <= 1'b0;
            state_r      <= S_BUSY;
          end else begin
            state_r      <= S_ISSUE;
          end
        end
        S_BUSY: begin
          if ((el.el_state == IDLE_CODE) && !el.door_open) begin
            busy    <= 1'b0;
            state_r <= S_SELECT;
          end else begin
            state_r <= S_BUSY;
          end
        end
        default: begin
          el.req_floor <= '0;
          el.open_req  <= 1'b0;
          busy         <= 1'b0;
          state_r      <= S_SELECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Directed scenario bench for floor_request_scheduler with a hand-driven elevator model.
module tb_floor_request_scheduler;

  logic       clk;
  logic       rst;
  logic [3:0] car_btn;
  logic [3:0] hall_btn;
  logic [3:0] pending;
  logic       dir;
  logic       busy;
  int         errors;
  int         checks;

  floor_request_scheduler_if bus ();

  floor_request_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .car_btn  (car_btn),
    .hall_btn (hall_btn),
    .el       (bus.master),
    .pending  (pending),
    .dir      (dir),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst          = 1'b1;
    car_btn      = 4'b0000;
    hall_btn     = 4'b0000;
    bus.floor    = 4'd1;
    bus.el_state = 4'd0;
    bus.door_open = 1'b0;
    bus.sos_en   = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Elevator acks, arrives at floor f with the door open, then returns to idle/closed.
  task automatic serve(input logic [3:0] f);
    bus.el_state = 4'd1;
    step();
    bus.floor     = f;
    bus.door_open = 1'b1;
    step();
    bus.el_state  = 4'd0;
    bus.door_open = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset_dut();
    checks++; if (bus.req_floor !== 4'd0) begin errors++; $display("FAIL reset_req: got %0d expected 0", bus.req_floor); end
    checks++; if (bus.open_req !== 1'b0) begin errors++; $display("FAIL reset_open: got %0b expected 0", bus.open_req); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL reset_pending: got %b expected 0000", pending); end
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL reset_dir: got %0b expected 0", dir); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_scan_up();
    reset_dut();
    car_btn = 4'b1100;
    step();
    car_btn = 4'b0000;
    checks++; if (pending !== 4'b1100) begin errors++; $display("FAIL up_lamp: got %b expected 1100", pending); end
    step();
    checks++; if (bus.req_floor !== 4'd3) begin errors++; $display("FAIL up_first: got %0d expected 3", bus.req_floor); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL up_busy: got %0b expected 1", busy); end
    bus.el_state = 4'd1;
    step();
    checks++; if (bus.req_floor !== 4'd0) begin errors++; $display("FAIL up_ack_clear: got %0d expected 0", bus.req_floor); end
    bus.floor = 4'd2;
    step();
    bus.floor = 4'd3;
    bus.door_open = 1'b1;
    step();
    checks++; if (pending !== 4'b1000) begin errors++; $display("FAIL up_served: got %b expected 1000", pending); end
    bus.el_state = 4'd0;
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL up_door_hold: got %0b expected 1", busy); end
    bus.door_open = 1'b0;
    step();
    step();
    checks++; if (bus.req_floor !== 4'd4) begin errors++; $display("FAIL up_second: got %0d expected 4", bus.req_floor); end
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL up_dir: got %0b expected 0", dir); end
    serve(4'd4);
    step();
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL up_empty: got %b expected 0000", pending); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL up_idle: got %0b expected 0", busy); end
  endtask

  task automatic test_reverse();
    reset_dut();
    bus.floor = 4'd3;
    car_btn = 4'b0011;
    step();
    car_btn = 4'b0000;
    step();
    checks++; if (bus.req_floor !== 4'd2) begin errors++; $display("FAIL rev_target: got %0d expected 2", bus.req_floor); end
    checks++; if (dir !== 1'b1) begin errors++; $display("FAIL rev_dir: got %0b expected 1", dir); end
    serve(4'd2);
    step();
    checks++; if (bus.req_floor !== 4'd1) begin errors++; $display("FAIL rev_next: got %0d expected 1", bus.req_floor); end
    checks++; if (dir !== 1'b1) begin errors++; $display("FAIL rev_dir_hold: got %0b expected 1", dir); end
    serve(4'd1);
  endtask

  task automatic test_reopen();
    reset_dut();
    bus.floor = 4'd2;
    hall_btn = 4'b0010;
    step();
    hall_btn = 4'b0000;
    step();
    checks++; if (bus.open_req !== 1'b1) begin errors++; $display("FAIL reopen_issue: got %0b expected 1", bus.open_req); end
    checks++; if (bus.req_floor !== 4'd0) begin errors++; $display("FAIL reopen_req: got %0d expected 0", bus.req_floor); end
    step();
    checks++; if (bus.open_req !== 1'b1) begin errors++; $display("FAIL reopen_hold: got %0b expected 1", bus.open_req); end
    bus.el_state = 4'd1;
    step();
    checks++; if (bus.open_req !== 1'b0) begin errors++; $display("FAIL reopen_ack: got %0b expected 0", bus.open_req); end
    bus.door_open = 1'b1;
    step();
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL reopen_clear: got %b expected 0000", pending); end
    bus.el_state = 4'd0;
    bus.door_open = 1'b0;
    step();
  endtask

  task automatic test_clear_and_invalid();
    reset_dut();
    bus.floor = 4'd3;
    bus.door_open = 1'b1;
    car_btn = 4'b0100;
    step();
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL clear_wins: got %b expected 0000", pending); end
    bus.floor = 4'd0;
    car_btn = 4'b0001;
    step();
    car_btn = 4'b0000;
    checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL invalid_noclear: got %b expected 0001", pending); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL invalid_noissue: got %0b expected 0", busy); end
    checks++; if (bus.req_floor !== 4'd0) begin errors++; $display("FAIL invalid_req: got %0d expected 0", bus.req_floor); end
    bus.door_open = 1'b0;
  endtask

  task automatic test_sos();
    reset_dut();
    car_btn = 4'b0100;
    step();
    car_btn = 4'b0000;
    step();
    bus.el_state = 4'd1;
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sos_pre_busy: got %0b expected 1", busy); end
    bus.sos_en = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sos_busy: got %0b expected 0", busy); end
    checks++; if (bus.req_floor !== 4'd0) begin errors++; $display("FAIL sos_req: got %0d expected 0", bus.req_floor); end
    car_btn = 4'b0001;
    step();
    checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL sos_frozen: got %b expected 0100", pending); end
    car_btn = 4'b0000;
    bus.sos_en = 1'b0;
    bus.el_state = 4'd0;
    step();
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sos_stays_halt_busy: got %0b expected 0", busy); end
    checks++; if (bus.req_floor !== 4'd0) begin errors++; $display("FAIL sos_stays_halt_req: got %0d expected 0", bus.req_floor); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL sos_rst_pending: got %b expected 0000", pending); end
    car_btn = 4'b0010;
    step();
    car_btn = 4'b0000;
    step();
    checks++; if (bus.req_floor !== 4'd2) begin errors++; $display("FAIL sos_resume: got %0d expected 2", bus.req_floor); end
  endtask

  task automatic test_rst_in_issue();
    reset_dut();
    bus.floor = 4'd3;
    car_btn = 4'b1010;
    step();
    car_btn = 4'b0000;
    step();
    checks++; if (bus.req_floor !== 4'd4) begin errors++; $display("FAIL rst_issue_req: got %0d expected 4", bus.req_floor); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus.req_floor !== 4'd0) begin errors++; $display("FAIL rst_mid_req: got %0d expected 0", bus.req_floor); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL rst_mid_pending: got %b expected 0000", pending); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %0b expected 0", busy); end
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL rst_mid_dir: got %0b expected 0", dir); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_scan_up();
    test_reverse();
    test_reopen();
    test_clear_and_invalid();
    test_sos();
    test_rst_in_issue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
